// File: rtl/fwd_hazard_ctrl.sv
// rtl/fwd_hazard_ctrl.sv - EX-stage forwarding select, load-use, flush and hold control
// Selects/state/counter are registered; pipeline enables are combinational from inputs.
module fwd_hazard_ctrl #(
  parameter int RA_W  = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [RA_W-1:0]  ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic             ex_is_link,
  input  logic [RA_W-1:0]  mem_rd,
  input  logic             mem_reg_write,
  input  logic             ex_branch_taken,
  input  logic             ext_stall,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [1:0]       ctrl_state,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_FLUSH      = 2'd2,
    ST_HOLD       = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [1:0]       r_sel_a;
  logic [1:0]       r_sel_b;
  logic [CNT_W-1:0] r_stall_count;

  logic w_a_valid, w_b_valid;
  logic w_a_ex, w_b_ex, w_a_mem, w_b_mem;
  logic w_load_use;
  logic w_cnt_inc;
  logic [1:0] w_sel_a, w_sel_b;

  // x0 is hardwired zero, so a read of it never matches a producer
  assign w_a_valid = id_use_rs1 && (id_rs1 != '0);
  assign w_b_valid = id_use_rs2 && (id_rs2 != '0);
  assign w_a_ex    = w_a_valid && ex_reg_write && (ex_rd == id_rs1);
  assign w_b_ex    = w_b_valid && ex_reg_write && (ex_rd == id_rs2);
  assign w_a_mem   = w_a_valid && mem_reg_write && (mem_rd == id_rs1);
  assign w_b_mem   = w_b_valid && mem_reg_write && (mem_rd == id_rs2);
  assign w_load_use = ex_mem_read && (w_a_ex || w_b_ex);

  assign w_sel_a = w_a_ex ? (ex_is_link ? 2'b11 : 2'b01) : (w_a_mem ? 2'b10 : 2'b00);
  assign w_sel_b = w_b_ex ? (ex_is_link ? 2'b11 : 2'b01) : (w_b_mem ? 2'b10 : 2'b00);

  always_comb begin
    w_next_state = ST_RUN;
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    w_cnt_inc    = 1'b0;
    if (reset) begin
      idex_bubble = 1'b1;
    end else if (ex_branch_taken) begin
      // redirect beats a memory stall so the new PC is never dropped
      w_next_state = ST_FLUSH;
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
    end else if (ext_stall) begin
      w_next_state = ST_HOLD;
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
    end else if (w_load_use) begin
      w_next_state = ST_LOAD_STALL;
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_bubble  = 1'b1;
      w_cnt_inc    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_RUN;
      r_sel_a       <= 2'b00;
      r_sel_b       <= 2'b00;
      r_stall_count <= '0;
    end else begin
      r_state <= w_next_state;
      case (w_next_state)
        ST_RUN: begin
          r_sel_a <= w_sel_a;
          r_sel_b <= w_sel_b;
        end
        ST_HOLD: begin
          r_sel_a <= r_sel_a;
          r_sel_b <= r_sel_b;
        end
        default: begin
          r_sel_a <= 2'b00;
          r_sel_b <= 2'b00;
        end
      endcase
      if (w_cnt_inc && (r_stall_count != '1)) begin
        r_stall_count <= r_stall_count + CNT_W'(1);
      end
    end
  end

  assign fwd_a_sel   = r_sel_a;
  assign fwd_b_sel   = r_sel_b;
  assign ctrl_state  = r_state;
  assign stall_count = r_stall_count;

endmodule
